// File: rtl/cache_mem_pkg.sv
// Shared types and block geometry for the cache/memory arbiter.
// Owner and state encodings used by the fill sequencer.
package cache_mem_pkg;

   localparam int DEF_BLOCK_WORDS = 8;
   localparam int BLOCK_BYTES = 2 * DEF_BLOCK_WORDS;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      TAG,
      WRITE
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_I,
      OWN_D
   } owner_t;

   // Byte-offset mask within one block of bw 16-bit words.
   function automatic int off_mask(input int bw);
      return 2 * bw - 1;
   endfunction

endpackage

// File: rtl/cache_mem_arbiter_fill_word_counter.sv
// Issue/receive word counters for one block fill.
// Generates the memory and data-array word addresses from the block base.
module fill_word_counter
   import cache_mem_pkg::*;
#(
   parameter int ADDR_W      = 16,
   parameter int BLOCK_WORDS = DEF_BLOCK_WORDS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              issue_en,
   input  logic              recv_en,
   input  logic [ADDR_W-1:0] base,
   output logic              issuing,
   output logic              last_word,
   output logic [ADDR_W-1:0] issue_addr,
   output logic [ADDR_W-1:0] recv_addr
);

   localparam int CW = $clog2(BLOCK_WORDS) + 1;
   localparam logic [CW-1:0] NW = CW'(BLOCK_WORDS);

   logic [CW-1:0] issue_cnt;
   logic [CW-1:0] recv_cnt;

   // Count issued addresses and returned words; cleared between fills.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issue_cnt <= '0;
         recv_cnt  <= '0;
      end else if (clr) begin
         issue_cnt <= '0;
         recv_cnt  <= '0;
      end else begin
         if (issue_en && issuing)
            issue_cnt <= issue_cnt + 1'b1;
         if (recv_en)
            recv_cnt <= recv_cnt + 1'b1;
      end
   end

   assign issuing    = issue_cnt < NW;
   assign last_word  = recv_en && (recv_cnt == NW - 1'b1);
   assign issue_addr = base + (ADDR_W'(issue_cnt) << 1);
   assign recv_addr  = base + (ADDR_W'(recv_cnt) << 1);

endmodule

// File: rtl/cache_mem_arbiter.sv
// Sole owner of main memory: arbitrates I/D block fills and
// write-through stores, and drives cache array strobes and stalls.
module cache_mem_arbiter
   import cache_mem_pkg::*;
#(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 16,
   parameter int BLOCK_WORDS = DEF_BLOCK_WORDS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              icache_miss,
   input  logic [ADDR_W-1:0] icache_addr,
   input  logic              dcache_miss,
   input  logic [ADDR_W-1:0] dcache_addr,
   input  logic              dwr_req,
   input  logic [ADDR_W-1:0] dwr_addr,
   input  logic [DATA_W-1:0] dwr_data,
   output logic              dwr_ack,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_enable,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_valid,
   output logic [ADDR_W-1:0] fill_addr,
   output logic [DATA_W-1:0] fill_data,
   output logic              i_wr_data_array,
   output logic              i_wr_tag_array,
   output logic              d_wr_data_array,
   output logic              d_wr_tag_array,
   output logic              i_busy,
   output logic              d_busy
);

   localparam logic [ADDR_W-1:0] MASK = ADDR_W'(off_mask(BLOCK_WORDS));

   state_t            state_q, state_d;
   owner_t            owner_q, owner_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   logic              in_fill;
   logic              issuing;
   logic              last_word;
   logic [ADDR_W-1:0] issue_addr;
   logic [ADDR_W-1:0] recv_addr;
   logic              data_stb;
   logic              tag_stb;
   logic              active;

   assign in_fill = state_q == FILL;

   fill_word_counter #(
      .ADDR_W      (ADDR_W),
      .BLOCK_WORDS (BLOCK_WORDS)
   ) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .clr        (!in_fill),
      .issue_en   (in_fill),
      .recv_en    (in_fill && mem_valid),
      .base       (base_q),
      .issuing    (issuing),
      .last_word  (last_word),
      .issue_addr (issue_addr),
      .recv_addr  (recv_addr)
   );

   // State, owner and latched request registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         owner_q <= OWN_NONE;
         base_q  <= '0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         base_q  <= base_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

   // Grant in IDLE (D miss, then store, then I miss); sequence fill/tag/write.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      base_d  = base_q;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      unique case (state_q)
         IDLE: begin
            owner_d = OWN_NONE;
            if (dcache_miss) begin
               state_d = FILL;
               owner_d = OWN_D;
               base_d  = dcache_addr & ~MASK;
            end else if (dwr_req) begin
               state_d = WRITE;
               owner_d = OWN_D;
               waddr_d = dwr_addr;
               wdata_d = dwr_data;
            end else if (icache_miss) begin
               state_d = FILL;
               owner_d = OWN_I;
               base_d  = icache_addr & ~MASK;
            end
         end
         FILL: begin
            if (last_word)
               state_d = TAG;
         end
         TAG:     state_d = IDLE;
         WRITE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Memory port, fill port and strobe decode from the current state.
   always_comb begin
      mem_enable = 1'b0;
      mem_wr     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      fill_addr  = '0;
      fill_data  = '0;
      dwr_ack    = 1'b0;
      data_stb   = 1'b0;
      tag_stb    = 1'b0;
      unique case (state_q)
         FILL: begin
            if (issuing) begin
               mem_enable = 1'b1;
               mem_addr   = issue_addr;
            end
            if (mem_valid) begin
               data_stb  = 1'b1;
               fill_addr = recv_addr;
               fill_data = mem_rdata;
            end
         end
         TAG: begin
            tag_stb   = 1'b1;
            fill_addr = base_q;
         end
         WRITE: begin
            mem_enable = 1'b1;
            mem_wr     = 1'b1;
            mem_addr   = waddr_q;
            mem_wdata  = wdata_q;
            dwr_ack    = 1'b1;
         end
         default: ;
      endcase
   end

   assign i_wr_data_array = data_stb && owner_q == OWN_I;
   assign d_wr_data_array = data_stb && owner_q == OWN_D;
   assign i_wr_tag_array  = tag_stb && owner_q == OWN_I;
   assign d_wr_tag_array  = tag_stb && owner_q == OWN_D;

   // Stall while a request is pending or this cache owns the memory.
   assign active = state_q != IDLE;
   assign i_busy = !rst && (icache_miss ||
                   (active && owner_q == OWN_I));
   assign d_busy = !rst && (dcache_miss || dwr_req ||
                   (active && owner_q == OWN_D));

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: memory model with fixed latency,
// event monitor and a schedule-level reference model.
module tb_cache_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        icache_miss, dcache_miss, dwr_req, dwr_ack;
   logic [15:0] icache_addr, dcache_addr, dwr_addr, dwr_data;
   logic [15:0] mem_addr, mem_wdata, fill_addr, fill_data;
   logic [15:0] mem_rdata = 16'h0;
   logic        mem_valid = 1'b0;
   logic        mem_enable, mem_wr;
   logic        i_wr_data_array, i_wr_tag_array;
   logic        d_wr_data_array, d_wr_tag_array;
   logic        i_busy, d_busy;

   typedef struct packed {
      logic [3:0]  kind;
      logic [15:0] cyc;
      logic [15:0] a;
      logic [15:0] d;
   } ev_t;

   typedef struct packed {
      int          due;
      logic [15:0] a;
   } rd_t;

   ev_t obs[$];
   ev_t exp_q[$];
   rd_t pend[$];
   bit  ib_h[0:16383];
   bit  db_h[0:16383];
   int  cyc = 0;
   int  lat = 4;
   int  viol = 0;
   int  itag_n = 0, dtag_n = 0, ack_n = 0;
   int  i_tgt = 0, d_tgt = 0, w_tgt = 0;
   logic i_want = 1'b0, d_want = 1'b0, w_want = 1'b0;
   logic [15:0] ia = 0, da = 0, wa = 0, wd = 0;
   logic [15:0] salt = 16'h3C5A;
   int  total = 0, bad = 0;

   // The caches drop their request once their tag (or ack) arrives.
   assign icache_miss = i_want && (itag_n < i_tgt);
   assign dcache_miss = d_want && (dtag_n < d_tgt);
   assign dwr_req     = w_want && (ack_n < w_tgt);
   assign icache_addr = ia;
   assign dcache_addr = da;
   assign dwr_addr    = wa;
   assign dwr_data    = wd;

   always #5 clk = ~clk;

   cache_mem_arbiter dut (
      .clk             (clk),
      .rst             (rst),
      .icache_miss     (icache_miss),
      .icache_addr     (icache_addr),
      .dcache_miss     (dcache_miss),
      .dcache_addr     (dcache_addr),
      .dwr_req         (dwr_req),
      .dwr_addr        (dwr_addr),
      .dwr_data        (dwr_data),
      .dwr_ack         (dwr_ack),
      .mem_addr        (mem_addr),
      .mem_enable      (mem_enable),
      .mem_wr          (mem_wr),
      .mem_wdata       (mem_wdata),
      .mem_rdata       (mem_rdata),
      .mem_valid       (mem_valid),
      .fill_addr       (fill_addr),
      .fill_data       (fill_data),
      .i_wr_data_array (i_wr_data_array),
      .i_wr_tag_array  (i_wr_tag_array),
      .d_wr_data_array (d_wr_data_array),
      .d_wr_tag_array  (d_wr_tag_array),
      .i_busy          (i_busy),
      .d_busy          (d_busy)
   );

   function automatic logic [15:0] mdata(input logic [15:0] a);
      return (a * 16'h9E37) ^ salt;
   endfunction

   function automatic ev_t mk(input int k, input int c,
                              input logic [15:0] a,
                              input logic [15:0] d);
      return {4'(k), 16'(c), a, d};
   endfunction

   // Memory returns each read lat cycles after issue; monitor at negedge.
   always begin
      @(posedge clk);
      cyc++;
      #1;
      mem_valid = 1'b0;
      mem_rdata = 16'h0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
         mem_valid = 1'b1;
         mem_rdata = mdata(pend[0].a);
         void'(pend.pop_front());
      end
      @(negedge clk);
      if (cyc < 16384) begin
         ib_h[cyc] = i_busy;
         db_h[cyc] = d_busy;
      end
      if (mem_enable && !mem_wr) begin
         obs.push_back(mk(0, cyc, mem_addr, 16'h0));
         pend.push_back({cyc + lat, mem_addr});
      end
      if (i_wr_data_array) obs.push_back(mk(1, cyc, fill_addr, fill_data));
      if (d_wr_data_array) obs.push_back(mk(2, cyc, fill_addr, fill_data));
      if (i_wr_tag_array) begin
         obs.push_back(mk(3, cyc, fill_addr, 16'h0));
         itag_n++;
      end
      if (d_wr_tag_array) begin
         obs.push_back(mk(4, cyc, fill_addr, 16'h0));
         dtag_n++;
      end
      if (mem_enable && mem_wr) obs.push_back(mk(5, cyc, mem_addr, mem_wdata));
      if (dwr_ack) begin
         obs.push_back(mk(6, cyc, 16'h0, 16'h0));
         ack_n++;
      end
      if (int'(i_wr_data_array) + int'(i_wr_tag_array) + int'(d_wr_data_array)
          + int'(d_wr_tag_array) + int'(dwr_ack) > 1)
         viol++;
      if (!mem_enable && (mem_wr || mem_addr != 0 || mem_wdata != 0))
         viol++;
   end

   // Reference model: expected events kept ordered by (cycle, kind).
   task automatic exp_push(input ev_t e);
      int i = 0;
      while (i < exp_q.size() &&
             {exp_q[i].cyc, exp_q[i].kind} <= {e.cyc, e.kind})
         i++;
      exp_q.insert(i, e);
   endtask

   // A fill granted before cycle t: 8 issues from t, words lat later,
   // tag after the last word, next grant decided in the idle cycle after.
   task automatic model_fill(inout int t, input int kd,
                             input logic [15:0] addr, output int tag_c);
      logic [15:0] base;
      base = addr - (addr % 16);
      for (int k = 0; k < 8; k++) begin
         exp_push(mk(0, t + k, base + 16'(2 * k), 16'h0));
         exp_push(mk(kd, t + lat + k, base + 16'(2 * k),
                     mdata(base + 16'(2 * k))));
      end
      tag_c = t + lat + 8;
      exp_push(mk(kd + 2, tag_c, base, 16'h0));
      t = tag_c + 2;
   endtask

   task automatic model_write(inout int t, input logic [15:0] a,
                              input logic [15:0] d, output int wc);
      exp_push(mk(5, t, a, d));
      exp_push(mk(6, t, 16'h0, 16'h0));
      wc = t;
      t = t + 2;
   endtask

   task automatic begin_at(output int c0, output int s);
      @(posedge clk);
      #1;
      c0 = cyc;
      s = obs.size();
      exp_q.delete();
   endtask

   task automatic raise_i(input logic [15:0] a);
      ia = a; i_tgt = itag_n + 1; i_want = 1'b1;
   endtask

   task automatic raise_d(input logic [15:0] a);
      da = a; d_tgt = dtag_n + 1; d_want = 1'b1;
   endtask

   task automatic raise_w(input logic [15:0] a, input logic [15:0] d);
      wa = a; wd = d; w_tgt = ack_n + 1; w_want = 1'b1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      raise_i(16'h1111);
      raise_w(16'h2222, 16'h3333);
      repeat (3) @(posedge clk);
      #2;
      total++;
      if ({mem_enable, mem_wr, mem_addr, mem_wdata, fill_addr, fill_data,
           dwr_ack, i_wr_data_array, i_wr_tag_array, d_wr_data_array,
           d_wr_tag_array, i_busy, d_busy} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: busy=%b%b en=%b addr=%h want all 0",
                  i_busy, d_busy, mem_enable, mem_addr);
      end
      i_want = 1'b0;
      w_want = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
   endtask

   task automatic test_i_fill;
      int c0, s, t, tc, n, nb;
      lat = 4;
      begin_at(c0, s);
      raise_i(16'h1234);
      t = c0 + 1;
      model_fill(t, 1, 16'h1234, tc);
      repeat (tc - c0 + 3) @(posedge clk);
      n = obs.size() - s;
      total++;
      if (n != exp_q.size()) begin
         bad++;
         $display("FAIL ifill_count: got %0d want %0d", n, exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < n; k++) begin
         total++;
         if (obs[s + k] !== exp_q[k]) begin
            bad++;
            $display("FAIL ifill_ev%0d: got %h want %h", k, obs[s + k], exp_q[k]);
         end
      end
      nb = 0;
      for (int c = c0; c <= tc; c++) if (!ib_h[c]) nb++;
      total++;
      if (tc != c0 + 13 || nb != 0 || ib_h[tc + 1] !== 1'b0) begin
         bad++;
         $display("FAIL ifill_busy: low=%0d after=%0b tag=%0d want 0,0,%0d",
                  nb, ib_h[tc + 1], tc - c0, 13);
      end
      nb = 0;
      for (int c = c0; c <= tc + 1; c++) if (db_h[c]) nb++;
      total++;
      if (nb != 0) begin
         bad++;
         $display("FAIL ifill_dbusy: got %0d high cycles want 0", nb);
      end
   endtask

   task automatic test_priority;
      int c0, s, t, dtc, itc, n, nb;
      lat = 4;
      begin_at(c0, s);
      raise_i(16'h7F3A);
      raise_d(16'h0408);
      t = c0 + 1;
      model_fill(t, 2, 16'h0408, dtc);
      model_fill(t, 1, 16'h7F3A, itc);
      repeat (itc - c0 + 3) @(posedge clk);
      n = obs.size() - s;
      total++;
      if (n != exp_q.size()) begin
         bad++;
         $display("FAIL prio_count: got %0d want %0d", n, exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < n; k++) begin
         total++;
         if (obs[s + k] !== exp_q[k]) begin
            bad++;
            $display("FAIL prio_ev%0d: got %h want %h", k, obs[s + k], exp_q[k]);
         end
      end
      nb = 0;
      for (int c = c0; c <= itc; c++) if (!ib_h[c]) nb++;
      for (int c = c0; c <= dtc; c++) if (!db_h[c]) nb++;
      total++;
      if (nb != 0 || ib_h[itc + 1] !== 1'b0 || db_h[dtc + 1] !== 1'b0) begin
         bad++;
         $display("FAIL prio_busy: low=%0d i_after=%0b d_after=%0b want 0,0,0",
                  nb, ib_h[itc + 1], db_h[dtc + 1]);
      end
   endtask

   task automatic test_write;
      int c0, s, t, wc, n;
      begin_at(c0, s);
      raise_w(16'h0040, 16'hBEEF);
      t = c0 + 1;
      model_write(t, 16'h0040, 16'hBEEF, wc);
      repeat (5) @(posedge clk);
      n = obs.size() - s;
      total++;
      if (n != exp_q.size()) begin
         bad++;
         $display("FAIL write_count: got %0d want %0d", n, exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < n; k++) begin
         total++;
         if (obs[s + k] !== exp_q[k]) begin
            bad++;
            $display("FAIL write_ev%0d: got %h want %h", k, obs[s + k], exp_q[k]);
         end
      end
      total++;
      if (db_h[c0] !== 1'b1 || db_h[wc] !== 1'b1 || db_h[wc + 1] !== 1'b0
          || ib_h[wc] !== 1'b0) begin
         bad++;
         $display("FAIL write_busy: d=%b%b%b i=%b want 110 0",
                  db_h[c0], db_h[wc], db_h[wc + 1], ib_h[wc]);
      end
   endtask

   task automatic test_no_preempt;
      int c0, s, t, itc, dtc, n, nb;
      lat = 4;
      begin_at(c0, s);
      raise_i(16'h1234);
      t = c0 + 1;
      model_fill(t, 1, 16'h1234, itc);
      model_fill(t, 2, 16'h0408, dtc);
      repeat (3) @(posedge clk);
      #1 raise_d(16'h0408);
      repeat (dtc - c0) @(posedge clk);
      n = obs.size() - s;
      total++;
      if (n != exp_q.size()) begin
         bad++;
         $display("FAIL nopre_count: got %0d want %0d", n, exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < n; k++) begin
         total++;
         if (obs[s + k] !== exp_q[k]) begin
            bad++;
            $display("FAIL nopre_ev%0d: got %h want %h", k, obs[s + k], exp_q[k]);
         end
      end
      nb = 0;
      for (int c = c0 + 3; c <= dtc; c++) if (!db_h[c]) nb++;
      total++;
      if (nb != 0 || db_h[c0 + 2] !== 1'b0 || db_h[dtc + 1] !== 1'b0) begin
         bad++;
         $display("FAIL nopre_dbusy: low=%0d before=%0b after=%0b want 0,0,0",
                  nb, db_h[c0 + 2], db_h[dtc + 1]);
      end
   endtask

   task automatic test_reset_mid_fill;
      int c0, s, t, tc, n;
      lat = 4;
      begin_at(c0, s);
      raise_i(16'h5678);
      repeat (6) @(posedge clk);
      #2;
      rst = 1'b1;
      s = obs.size();
      #1;
      total++;
      if ({mem_enable, mem_wr, mem_addr, mem_wdata, fill_addr, fill_data,
           dwr_ack, i_wr_data_array, i_wr_tag_array, d_wr_data_array,
           d_wr_tag_array, i_busy, d_busy} !== '0) begin
         bad++;
         $display("FAIL rstmid_outputs: en=%b ida=%b fd=%h ib=%b want 0",
                  mem_enable, i_wr_data_array, fill_data, i_busy);
      end
      i_want = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (10) @(posedge clk);
      total++;
      if (obs.size() != s || itag_n >= i_tgt) begin
         bad++;
         $display("FAIL rstmid_quiet: got %0d events tag=%0d want 0, no tag",
                  obs.size() - s, itag_n);
      end
      begin_at(c0, s);
      raise_i(16'h5678);
      t = c0 + 1;
      model_fill(t, 1, 16'h5678, tc);
      repeat (tc - c0 + 3) @(posedge clk);
      n = obs.size() - s;
      total++;
      if (n != exp_q.size()) begin
         bad++;
         $display("FAIL rstmid_count: got %0d want %0d", n, exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < n; k++) begin
         total++;
         if (obs[s + k] !== exp_q[k]) begin
            bad++;
            $display("FAIL rstmid_ev%0d: got %h want %h", k, obs[s + k], exp_q[k]);
         end
      end
   endtask

   task automatic test_store_miss;
      int c0, s, t, dtc, wc, n, nb;
      logic [15:0] d;
      lat = 3;
      d = 16'($urandom);
      begin_at(c0, s);
      raise_d(16'h0A16);
      raise_w(16'h0A12, d);
      t = c0 + 1;
      model_fill(t, 2, 16'h0A16, dtc);
      model_write(t, 16'h0A12, d, wc);
      repeat (wc - c0 + 4) @(posedge clk);
      n = obs.size() - s;
      total++;
      if (n != exp_q.size()) begin
         bad++;
         $display("FAIL stmiss_count: got %0d want %0d", n, exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < n; k++) begin
         total++;
         if (obs[s + k] !== exp_q[k]) begin
            bad++;
            $display("FAIL stmiss_ev%0d: got %h want %h", k, obs[s + k], exp_q[k]);
         end
      end
      nb = 0;
      for (int c = c0; c <= wc; c++) if (!db_h[c]) nb++;
      total++;
      if (nb != 0 || db_h[wc + 1] !== 1'b0) begin
         bad++;
         $display("FAIL stmiss_busy: low=%0d after=%0b want 0,0",
                  nb, db_h[wc + 1]);
      end
   endtask

   task automatic test_random;
      int c0, s, t, n, nb, itc, dtc, wc, m, iend, dend;
      logic [15:0] ra_i, ra_d, ra_w, rd;
      for (int it = 0; it < 8; it++) begin
         lat = $urandom_range(1, 6);
         m = $urandom_range(1, 7);
         ra_i = 16'($urandom);
         ra_d = 16'($urandom);
         ra_w = 16'($urandom) & 16'hFFFE;
         rd = 16'($urandom);
         begin_at(c0, s);
         t = c0 + 1;
         iend = 0;
         dend = 0;
         if (m[1]) begin
            raise_d(ra_d);
            model_fill(t, 2, ra_d, dtc);
            dend = dtc;
         end
         if (m[2]) begin
            raise_w(ra_w, rd);
            model_write(t, ra_w, rd, wc);
            dend = wc;
         end
         if (m[0]) begin
            raise_i(ra_i);
            model_fill(t, 1, ra_i, itc);
            iend = itc;
         end
         repeat (t - c0 + 3) @(posedge clk);
         n = obs.size() - s;
         total++;
         if (n != exp_q.size()) begin
            bad++;
            $display("FAIL rnd%0d_count: got %0d want %0d", it, n, exp_q.size());
         end
         for (int k = 0; k < exp_q.size() && k < n; k++) begin
            total++;
            if (obs[s + k] !== exp_q[k]) begin
               bad++;
               $display("FAIL rnd%0d_ev%0d: got %h want %h",
                        it, k, obs[s + k], exp_q[k]);
            end
         end
         nb = 0;
         if (m[0]) begin
            for (int c = c0; c <= iend; c++) if (!ib_h[c]) nb++;
            if (ib_h[iend + 1]) nb++;
         end
         if (m[2:1] != 0) begin
            for (int c = c0; c <= dend; c++) if (!db_h[c]) nb++;
            if (db_h[dend + 1]) nb++;
         end
         total++;
         if (nb != 0) begin
            bad++;
            $display("FAIL rnd%0d_busy: got %0d wrong cycles want 0", it, nb);
         end
      end
   endtask

   task automatic test_invariants;
      total++;
      if (viol != 0) begin
         bad++;
         $display("FAIL invariants: got %0d violating cycles want 0", viol);
      end
   endtask

   initial begin
      salt = 16'($urandom);
      test_reset();
      test_i_fill();
      test_priority();
      test_write();
      test_no_preempt();
      test_reset_mid_fill();
      test_store_miss();
      test_random();
      test_invariants();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
